rf_wb_arbiter: RTL and testbench

//  Writeback controller for the 2R1W integer register file. Shares the single RF write port

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_wb_arbiter_if.sv | 18 +
 rtl/rf_wb_rr_grant.sv | 49 ++++
 rtl/rf_wb_arbiter.sv | 98 +++++++++
 tb/tb_rf_wb_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, write-port record and writeback requester indices.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

  typedef struct packed {
    logic             we;
    logic [RF_AW-1:0] addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback requester bundle: one valid/ready handshake plus address and data per requester.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_waddr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;

  modport master (output req_valid, output req_waddr, output req_wdata, input req_ready);
  modport slave  (input req_valid, input req_waddr, input req_wdata, output req_ready);

endinterface

// File: rtl/rf_wb_rr_grant.sv
// One-hot grant over NUM_REQ requests. RF_WB_RR_ARB_EN selects round-robin with a pointer;
// otherwise a plain lowest-index-wins priority encoder with no state.
module rf_wb_rr_grant #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef RF_WB_RR_ARB_EN
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;

  // Search starts at the pointer; the pointer moves to just past the winner.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = PW'((int'(ptr_q) + off) % NUM_REQ);
      if (req_i[idx] && (gnt_o == '0)) begin
        gnt_o[idx] = 1'b1;
        ptr_d      = PW'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_ni;

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && (gnt_o == '0)) gnt_o[i] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with in-flight destination scoreboard.
// Arbitration policy: round-robin when RF_WB_RR_ARB_EN is defined, fixed priority otherwise.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = RF_AW,
  parameter int DW      = RF_DW
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rf_wb_arbiter_if.slave        wb,
  input  logic                  issue_valid_i,
  input  logic [AW-1:0]         issue_rd_i,
  output logic                  issue_ready_o,
  input  logic [AW-1:0]         raddr_a_i,
  input  logic [AW-1:0]         raddr_b_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o,
  input  logic                  flush_i,
  output logic                  rf_we_o,
  output logic [AW-1:0]         rf_waddr_o,
  output logic [DW-1:0]         rf_wdata_o
);

  localparam int NREG = 2 ** AW;

  logic [NUM_REQ-1:0] gnt;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_data;
  logic               accept;
  rf_wr_t             wr_q;
  logic [NREG-1:0]    pend_q;
  logic [NREG-1:0]    pend_d;
  logic               issue_fire;

  rf_wb_rr_grant #(.NUM_REQ(NUM_REQ)) u_grant (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req_i  (wb.req_valid & {NUM_REQ{~flush_i}}),
    .gnt_o  (gnt)
  );

  assign wb.req_ready = gnt;
  assign accept       = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = sel_addr | wb.req_waddr[i*AW +: AW];
        sel_data = sel_data | wb.req_wdata[i*DW +: DW];
      end
    end
  end

  // The RF never stalls, so the port register reloads or clears every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
    end else if (flush_i || !accept) begin
      wr_q <= '0;
    end else begin
      wr_q.we   <= (sel_addr != '0);
      wr_q.addr <= sel_addr;
      wr_q.data <= sel_data;
    end
  end

  assign rf_we_o    = wr_q.we;
  assign rf_waddr_o = wr_q.addr;
  assign rf_wdata_o = wr_q.data;

  assign issue_ready_o = !pend_q[issue_rd_i] || (wr_q.we && (wr_q.addr == issue_rd_i));
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != '0) && !flush_i;

  assign hazard_a_o = pend_q[raddr_a_i] && !(wr_q.we && (wr_q.addr == raddr_a_i));
  assign hazard_b_o = pend_q[raddr_b_i] && !(wr_q.we && (wr_q.addr == raddr_b_i));

  // Set after clear so a re-issue in the retiring write's cycle keeps the register pending.
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (wr_q.we)    pend_d[wr_q.addr]  = 1'b0;
      if (issue_fire) pend_d[issue_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, scoreboard hazards, arbitration, x0, flush.
module tb_rf_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic [4:0]  raddr_a_i;
  logic [4:0]  raddr_b_i;
  logic        hazard_a_o;
  logic        hazard_b_o;
  logic        flush_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;

  int checks = 0;
  int passed = 0;

  rf_wb_arbiter_if #(.NUM_REQ(3), .AW(5), .DW(32)) wb ();

  rf_wb_arbiter #(.NUM_REQ(3), .AW(5), .DW(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .wb            (wb),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .raddr_a_i     (raddr_a_i),
    .raddr_b_i     (raddr_b_i),
    .hazard_a_o    (hazard_a_o),
    .hazard_b_o    (hazard_b_o),
    .flush_i       (flush_i),
    .rf_we_o       (rf_we_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    wb.req_valid  = '0;
    wb.req_waddr  = '0;
    wb.req_wdata  = '0;
    issue_valid_i = 1'b0;
    issue_rd_i    = '0;
    raddr_a_i     = '0;
    raddr_b_i     = '0;
    flush_i       = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    idle_inputs();
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    #12;
    checks++; if (rf_we_o !== 1'b0) $display("FAIL reset_we: got %0h expected 0", rf_we_o); else passed++;
    checks++; if (rf_waddr_o !== 5'd0) $display("FAIL reset_waddr: got %0h expected 0", rf_waddr_o); else passed++;
    checks++; if (rf_wdata_o !== 32'd0) $display("FAIL reset_wdata: got %0h expected 0", rf_wdata_o); else passed++;
    checks++; if (wb.req_ready !== 3'b000) $display("FAIL reset_ready: got %0h expected 0", wb.req_ready); else passed++;
    checks++; if (issue_ready_o !== 1'b1) $display("FAIL reset_issue_ready: got %0h expected 1", issue_ready_o); else passed++;
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) $display("FAIL reset_hazard: got %0h expected 0", {hazard_a_o, hazard_b_o}); else passed++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++; if (rf_we_o !== 1'b0) $display("FAIL idle_we: got %0h expected 0", rf_we_o); else passed++;
    end
  endtask

  task automatic test_alu_write();
    @(negedge clk_i);
    wb.req_valid = 3'b001;
    wb.req_waddr = {5'd0, 5'd0, 5'd5};
    wb.req_wdata = {32'd0, 32'd0, 32'hDEADBEEF};
    #1;
    checks++; if (wb.req_ready !== 3'b001) $display("FAIL alu_ready: got %0h expected 1", wb.req_ready); else passed++;
    @(negedge clk_i);
    wb.req_valid = '0;
    checks++; if (rf_we_o !== 1'b1) $display("FAIL alu_we: got %0h expected 1", rf_we_o); else passed++;
    checks++; if (rf_waddr_o !== 5'd5) $display("FAIL alu_waddr: got %0h expected 5", rf_waddr_o); else passed++;
    checks++; if (rf_wdata_o !== 32'hDEADBEEF) $display("FAIL alu_wdata: got %0h expected deadbeef", rf_wdata_o); else passed++;
    @(negedge clk_i);
    checks++; if (rf_we_o !== 1'b0) $display("FAIL alu_we_pulse: got %0h expected 0", rf_we_o); else passed++;
  endtask

  task automatic test_hazard();
    @(negedge clk_i);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd7;
    #1;
    checks++; if (issue_ready_o !== 1'b1) $display("FAIL haz_first_issue: got %0h expected 1", issue_ready_o); else passed++;
    @(negedge clk_i);
    raddr_a_i = 5'd7;
    raddr_b_i = 5'd5;
    #1;
    checks++; if (hazard_a_o !== 1'b1) $display("FAIL haz_a_set: got %0h expected 1", hazard_a_o); else passed++;
    checks++; if (hazard_b_o !== 1'b0) $display("FAIL haz_b_clean: got %0h expected 0", hazard_b_o); else passed++;
    checks++; if (issue_ready_o !== 1'b0) $display("FAIL haz_waw_stall: got %0h expected 0", issue_ready_o); else passed++;
    @(negedge clk_i);
    wb.req_valid = 3'b010;
    wb.req_waddr = {5'd0, 5'd7, 5'd0};
    wb.req_wdata = {32'd0, 32'h77, 32'd0};
    #1;
    checks++; if (wb.req_ready !== 3'b010) $display("FAIL haz_lsu_ready: got %0h expected 2", wb.req_ready); else passed++;
    checks++; if (hazard_a_o !== 1'b1) $display("FAIL haz_a_hold: got %0h expected 1", hazard_a_o); else passed++;
    checks++; if (issue_ready_o !== 1'b0) $display("FAIL haz_waw_hold: got %0h expected 0", issue_ready_o); else passed++;
    @(negedge clk_i);
    wb.req_valid = '0;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd7) $display("FAIL haz_lsu_write: got we=%0h addr=%0h expected we=1 addr=7", rf_we_o, rf_waddr_o); else passed++;
    checks++; if (hazard_a_o !== 1'b0) $display("FAIL haz_a_bypass: got %0h expected 0", hazard_a_o); else passed++;
    checks++; if (issue_ready_o !== 1'b1) $display("FAIL haz_reissue_ready: got %0h expected 1", issue_ready_o); else passed++;
    @(negedge clk_i);
    issue_valid_i = 1'b0;
    #1;
    checks++; if (hazard_a_o !== 1'b1) $display("FAIL haz_set_wins: got %0h expected 1", hazard_a_o); else passed++;
    wb.req_valid = 3'b010;
    @(negedge clk_i);
    wb.req_valid = '0;
    checks++; if (hazard_a_o !== 1'b0) $display("FAIL haz_second_bypass: got %0h expected 0", hazard_a_o); else passed++;
    @(negedge clk_i);
    checks++; if (hazard_a_o !== 1'b0) $display("FAIL haz_cleared: got %0h expected 0", hazard_a_o); else passed++;
    idle_inputs();
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_gnt [6];
    logic [4:0] exp_addr;
`ifdef RF_WB_RR_ARB_EN
    exp_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_gnt = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
`endif
    apply_reset();
    wb.req_valid = 3'b111;
    wb.req_waddr = {5'd3, 5'd2, 5'd1};
    wb.req_wdata = {32'h333, 32'h222, 32'h111};
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (wb.req_ready !== exp_gnt[k]) $display("FAIL arb_grant%0d: got %0h expected %0h", k, wb.req_ready, exp_gnt[k]); else passed++;
      @(negedge clk_i);
      exp_addr = (exp_gnt[k] == 3'b001) ? 5'd1 : (exp_gnt[k] == 3'b010) ? 5'd2 : 5'd3;
      checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== exp_addr) $display("FAIL arb_write%0d: got we=%0h addr=%0h expected we=1 addr=%0h", k, rf_we_o, rf_waddr_o, exp_addr); else passed++;
    end
    idle_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_x0();
    @(negedge clk_i);
    wb.req_valid  = 3'b100;
    wb.req_waddr  = {5'd0, 5'd0, 5'd0};
    wb.req_wdata  = {32'h1, 32'd0, 32'd0};
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd0;
    #1;
    checks++; if (wb.req_ready !== 3'b100) $display("FAIL x0_ready: got %0h expected 4", wb.req_ready); else passed++;
    checks++; if (issue_ready_o !== 1'b1) $display("FAIL x0_issue_ready: got %0h expected 1", issue_ready_o); else passed++;
    @(negedge clk_i);
    wb.req_valid  = '0;
    issue_valid_i = 1'b0;
    checks++; if (rf_we_o !== 1'b0) $display("FAIL x0_no_write: got %0h expected 0", rf_we_o); else passed++;
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) $display("FAIL x0_no_hazard: got %0h expected 0", {hazard_a_o, hazard_b_o}); else passed++;
    @(negedge clk_i);
    checks++; if (hazard_a_o !== 1'b0) $display("FAIL x0_no_hazard_late: got %0h expected 0", hazard_a_o); else passed++;
  endtask

  task automatic test_flush();
    @(negedge clk_i);
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd3;
    @(negedge clk_i);
    issue_rd_i    = 5'd9;
    @(negedge clk_i);
    issue_valid_i = 1'b0;
    raddr_a_i     = 5'd3;
    raddr_b_i     = 5'd9;
    #1;
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b11) $display("FAIL flush_pre_hazard: got %0h expected 3", {hazard_a_o, hazard_b_o}); else passed++;
    @(negedge clk_i);
    flush_i       = 1'b1;
    wb.req_valid  = 3'b001;
    wb.req_waddr  = {5'd0, 5'd0, 5'd4};
    wb.req_wdata  = {32'd0, 32'd0, 32'h44};
    issue_valid_i = 1'b1;
    issue_rd_i    = 5'd12;
    #1;
    checks++; if (wb.req_ready !== 3'b000) $display("FAIL flush_no_grant: got %0h expected 0", wb.req_ready); else passed++;
    @(negedge clk_i);
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    checks++; if (rf_we_o !== 1'b0) $display("FAIL flush_we: got %0h expected 0", rf_we_o); else passed++;
    checks++; if ({hazard_a_o, hazard_b_o} !== 2'b00) $display("FAIL flush_cleared: got %0h expected 0", {hazard_a_o, hazard_b_o}); else passed++;
    raddr_a_i = 5'd12;
    #1;
    checks++; if (hazard_a_o !== 1'b0) $display("FAIL flush_issue_ignored: got %0h expected 0", hazard_a_o); else passed++;
    checks++; if (wb.req_ready !== 3'b001) $display("FAIL flush_regrant: got %0h expected 1", wb.req_ready); else passed++;
    @(negedge clk_i);
    wb.req_valid = '0;
    checks++; if (rf_we_o !== 1'b1 || rf_waddr_o !== 5'd4 || rf_wdata_o !== 32'h44) $display("FAIL flush_retry_write: got we=%0h addr=%0h data=%0h expected we=1 addr=4 data=44", rf_we_o, rf_waddr_o, rf_wdata_o); else passed++;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_hazard();
    test_arbitration();
    test_x0();
    test_flush();
    @(negedge clk_i);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
